dram_cmd_scheduler: RTL

//   Sequences DRAM commands for one request at a time, fed by the bank/row/col fields out of

---
 rtl/dram_cmd_scheduler.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/dram_cmd_scheduler.sv
// Open-page DRAM command sequencer: one request at a time, PRE/ACT only on a row miss,
// tRP/tRCD/tCL spacing between commands, plus a precharge-all flush.
module dram_cmd_scheduler #(
  parameter int ADDR_WIDTH   = 13,
  parameter int NUM_OF_BANKS = 8,
  parameter int NUM_OF_ROWS  = 128,
  parameter int NUM_OF_COLS  = 8,
  parameter int T_RP         = 3,
  parameter int T_RCD        = 3,
  parameter int T_CL         = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic                            req_write,
  input  logic [$clog2(NUM_OF_BANKS)-1:0] req_bank_id,
  input  logic [$clog2(NUM_OF_ROWS)-1:0]  req_row_id,
  input  logic [$clog2(NUM_OF_COLS)-1:0]  req_col_id,
  input  logic                            flush_req,
  output logic                            cmd_valid,
  output logic [1:0]                      cmd_type,
  output logic [$clog2(NUM_OF_BANKS)-1:0] cmd_bank_id,
  output logic [$clog2(NUM_OF_ROWS)-1:0]  cmd_row_id,
  output logic [$clog2(NUM_OF_COLS)-1:0]  cmd_col_id,
  output logic                            done,
  output logic                            row_hit,
  output logic                            flush_done
);
  localparam int BW    = $clog2(NUM_OF_BANKS);
  localparam int RW    = $clog2(NUM_OF_ROWS);
  localparam int CLW   = $clog2(NUM_OF_COLS);
  localparam int T_MAX = (T_RP > T_RCD) ? ((T_RP > T_CL) ? T_RP : T_CL)
                                        : ((T_RCD > T_CL) ? T_RCD : T_CL);
  localparam int CW    = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] RP_LD   = CW'(T_RP - 1);
  localparam logic [CW-1:0] RCD_LD  = CW'(T_RCD - 1);
  localparam logic [CW-1:0] CL_LD   = CW'(T_CL - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] CMD_ACT = 2'd0;
  localparam logic [1:0] CMD_RD  = 2'd1;
  localparam logic [1:0] CMD_WR  = 2'd2;
  localparam logic [1:0] CMD_PRE = 2'd3;

  if (ADDR_WIDTH != BW + RW + CLW) begin : g_bad_addr_width
    $error("ADDR_WIDTH must equal log2(banks*rows*cols)");
  end

  typedef enum logic [3:0] {
    IDLE, PRE, PRE_WAIT, ACT, ACT_WAIT, ACCESS, CAS_WAIT, FLUSH, FLUSH_WAIT
  } state_t;

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    lat_write;
  logic                    lat_hit;
  logic [BW-1:0]           lat_bank;
  logic [RW-1:0]           lat_row;
  logic [CLW-1:0]          lat_col;
  logic [NUM_OF_BANKS-1:0] open_valid;
  logic [RW-1:0]           open_row [NUM_OF_BANKS];

  logic                    req_hit;
  logic                    act_issue;
  logic [BW-1:0]           flush_bank;
  logic                    flush_any;
  logic                    flush_more;
  logic [NUM_OF_BANKS-1:0] flush_rest;

  assign req_hit   = open_valid[req_bank_id] && (open_row[req_bank_id] == req_row_id);
  assign act_issue = (state == ACT) || ((state == PRE_WAIT) && (cnt == '0));

  // Lowest-index open bank is the next one a flush precharges.
  always_comb begin
    flush_bank = '0;
    flush_any  = 1'b0;
    for (int b = NUM_OF_BANKS - 1; b >= 0; b--) begin
      if (open_valid[b]) begin
        flush_bank = BW'(b);
        flush_any  = 1'b1;
      end
    end
    flush_rest             = open_valid;
    flush_rest[flush_bank] = 1'b0;
    flush_more             = |flush_rest;
  end

  // Row tags carry no reset; open_valid alone says whether a tag means anything.
  always_ff @(posedge clk) begin
    if (act_issue) open_row[lat_bank] <= lat_row;
  end

  // Handshake: a request is taken on a rising edge where req_valid and req_ready are both 1
  // and flush_req is 0; flush_req seen in IDLE wins and the request stays pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_write   <= 1'b0;
      lat_hit     <= 1'b0;
      lat_bank    <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      open_valid  <= '0;
      req_ready   <= 1'b1;
      cmd_valid   <= 1'b0;
      cmd_type    <= '0;
      cmd_bank_id <= '0;
      cmd_row_id  <= '0;
      cmd_col_id  <= '0;
      done        <= 1'b0;
      row_hit     <= 1'b0;
      flush_done  <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      done       <= 1'b0;
      row_hit    <= 1'b0;
      flush_done <= 1'b0;
      req_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_req) begin
            state <= FLUSH;
          end else if (req_valid && req_ready) begin
            lat_write <= req_write;
            lat_bank  <= req_bank_id;
            lat_row   <= req_row_id;
            lat_col   <= req_col_id;
            lat_hit   <= req_hit;
            if (req_hit)                       state <= ACCESS;
            else if (open_valid[req_bank_id])  state <= PRE;
            else                               state <= ACT;
          end else begin
            req_ready <= 1'b1;
          end
        end
        PRE: begin
          cmd_valid            <= 1'b1;
          cmd_type             <= CMD_PRE;
          cmd_bank_id          <= lat_bank;
          cmd_row_id           <= lat_row;
          cmd_col_id           <= lat_col;
          open_valid[lat_bank] <= 1'b0;
          cnt                  <= RP_LD;
          state                <= PRE_WAIT;
        end
        PRE_WAIT, ACT: begin
          // act_issue covers both the direct ACT and the end of the precharge wait.
          if (act_issue) begin
            cmd_valid            <= 1'b1;
            cmd_type             <= CMD_ACT;
            cmd_bank_id          <= lat_bank;
            cmd_row_id           <= lat_row;
            cmd_col_id           <= lat_col;
            open_valid[lat_bank] <= 1'b1;
            cnt                  <= RCD_LD;
            state                <= ACT_WAIT;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        ACT_WAIT, ACCESS: begin
          if (state == ACCESS || cnt == '0) begin
            cmd_valid   <= 1'b1;
            cmd_type    <= lat_write ? CMD_WR : CMD_RD;
            cmd_bank_id <= lat_bank;
            cmd_row_id  <= lat_row;
            cmd_col_id  <= lat_col;
            cnt         <= CL_LD;
            state       <= CAS_WAIT;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        CAS_WAIT: begin
          if (cnt == '0) begin
            done    <= 1'b1;
            row_hit <= lat_hit;
            state   <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        FLUSH: begin
          if (!flush_any) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cmd_valid              <= 1'b1;
            cmd_type               <= CMD_PRE;
            cmd_bank_id            <= flush_bank;
            cmd_row_id             <= '0;
            cmd_col_id             <= '0;
            open_valid[flush_bank] <= 1'b0;
            if (!flush_more) begin
              cnt   <= RP_LD;
              state <= FLUSH_WAIT;
            end
          end
        end
        FLUSH_WAIT: begin
          if (cnt == '0) begin
            flush_done <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
